// File: rtl/maple_out.sv
// Maple bus transmitter: frames bytes from a show-ahead TX FIFO into the
// start pattern, MSB-first two-phase data and end pattern on pin1/pin5.
module maple_out #(
    parameter int SLOT_CYCLES = 8,
    parameter int LEN_W       = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             send,
    input  logic [LEN_W-1:0] frame_len,
    input  logic [7:0]       fifo_data,
    input  logic             fifo_empty,
    output logic             fifo_consume,
    output logic             busy,
    output logic             done,
    output logic             pin1,
    output logic             pin5,
    output logic             oe
);

    localparam int TW = $clog2(SLOT_CYCLES);
    localparam logic [TW-1:0] SLOT_LAST = TW'(SLOT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_START,
        ST_FETCH,
        ST_DATA,
        ST_END
    } state_t;

    state_t            state_r;
    logic [3:0]        slot_r;
    logic [TW-1:0]     timer_r;
    logic [LEN_W-1:0]  remain_r;
    logic [7:0]        shift_r;
    logic [7:0]        shift_nxt_s;

    // (pin1,pin5) for start slot S0..S11; S2..S9 alternate (0,0)/(0,1)
    function automatic logic [1:0] start_pair(input logic [3:0] idx);
        case (idx)
            4'd0:    start_pair = 2'b11;
            4'd1:    start_pair = 2'b01;
            4'd10:   start_pair = 2'b11;
            4'd11:   start_pair = 2'b10;
            default: start_pair = idx[0] ? 2'b01 : 2'b00;
        endcase
    endfunction

    // (pin1,pin5) for one phase of a bit-pair; bits = {earlier bit, later bit}
    function automatic logic [1:0] data_pair(input logic [1:0] phase, input logic [1:0] bits);
        case (phase)
            2'd0:    data_pair = {1'b1, bits[1]};
            2'd1:    data_pair = {1'b0, bits[1]};
            2'd2:    data_pair = {bits[0], 1'b1};
            default: data_pair = {bits[0], 1'b0};
        endcase
    endfunction

    // (pin1,pin5) for end slot E0..E7
    function automatic logic [1:0] end_pair(input logic [2:0] idx);
        case (idx)
            3'd0:    end_pair = 2'b11;
            3'd1:    end_pair = 2'b10;
            3'd2:    end_pair = 2'b00;
            3'd3:    end_pair = 2'b10;
            3'd4:    end_pair = 2'b00;
            3'd5:    end_pair = 2'b10;
            default: end_pair = 2'b11;
        endcase
    endfunction

    // Shift register advances by one bit-pair after the fourth phase of each pair
    always_comb begin
        shift_nxt_s = shift_r;
        if (slot_r[1:0] == 2'b11) begin
            shift_nxt_s = {shift_r[5:0], 2'b00};
        end else begin
            shift_nxt_s = shift_r;
        end
    end

    // Frame sequencer: slot timer, byte counter and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            slot_r       <= 4'd0;
            timer_r      <= '0;
            remain_r     <= '0;
            shift_r      <= 8'h00;
            pin1         <= 1'b1;
            pin5         <= 1'b1;
            oe           <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            fifo_consume <= 1'b0;
        end else begin
            done         <= 1'b0;
            fifo_consume <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // a send coinciding with the done pulse belongs to the old frame
                    if (send && !done) begin
                        remain_r <= frame_len;
                        state_r  <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    oe           <= 1'b1;
                    busy         <= 1'b1;
                    {pin1, pin5} <= start_pair(4'd0);
                    slot_r       <= 4'd0;
                    timer_r      <= SLOT_LAST;
                    state_r      <= ST_START;
                end
                ST_START: begin
                    if (timer_r != '0) begin
                        timer_r <= timer_r - TW'(1);
                    end else if (slot_r != 4'd11) begin
                        slot_r       <= slot_r + 4'd1;
                        {pin1, pin5} <= start_pair(slot_r + 4'd1);
                        timer_r      <= SLOT_LAST;
                    end else if (remain_r == '0) begin
                        slot_r       <= 4'd0;
                        {pin1, pin5} <= end_pair(3'd0);
                        timer_r      <= SLOT_LAST;
                        state_r      <= ST_END;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // lines and timer hold while the FIFO is empty
                    if (!fifo_empty) begin
                        fifo_consume <= 1'b1;
                        shift_r      <= fifo_data;
                        remain_r     <= remain_r - LEN_W'(1);
                        slot_r       <= 4'd0;
                        {pin1, pin5} <= data_pair(2'd0, fifo_data[7:6]);
                        timer_r      <= SLOT_LAST;
                        state_r      <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (timer_r != '0) begin
                        timer_r <= timer_r - TW'(1);
                    end else if (slot_r != 4'd15) begin
                        slot_r       <= slot_r + 4'd1;
                        shift_r      <= shift_nxt_s;
                        {pin1, pin5} <= data_pair(slot_r[1:0] + 2'd1, shift_nxt_s[7:6]);
                        timer_r      <= SLOT_LAST;
                    end else if (remain_r == '0) begin
                        slot_r       <= 4'd0;
                        {pin1, pin5} <= end_pair(3'd0);
                        timer_r      <= SLOT_LAST;
                        state_r      <= ST_END;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_END: begin
                    if (timer_r != '0) begin
                        timer_r <= timer_r - TW'(1);
                    end else if (slot_r[2:0] != 3'd7) begin
                        slot_r       <= slot_r + 4'd1;
                        {pin1, pin5} <= end_pair(slot_r[2:0] + 3'd1);
                        timer_r      <= SLOT_LAST;
                    end else begin
                        pin1    <= 1'b1;
                        pin5    <= 1'b1;
                        oe      <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maple_out.sv
// Directed bench for maple_out: table of frames decoded by an edge-based
// receiver model, plus hand sequences for slot trace, send-at-done and reset.
module tb_maple_out;

    localparam int SLOT  = 4;
    localparam int LEN_W = 11;

    logic             clk = 1'b0;
    logic             rst;
    logic             send;
    logic [LEN_W-1:0] frame_len;
    logic [7:0]       fifo_data;
    logic             fifo_empty;
    logic             fifo_consume;
    logic             busy;
    logic             done;
    logic             pin1;
    logic             pin5;
    logic             oe;

    maple_out #(.SLOT_CYCLES(SLOT), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .send         (send),
        .frame_len    (frame_len),
        .fifo_data    (fifo_data),
        .fifo_empty   (fifo_empty),
        .fifo_consume (fifo_consume),
        .busy         (busy),
        .done         (done),
        .pin1         (pin1),
        .pin5         (pin5),
        .oe           (oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          len;
        logic [31:0] bytes;      // first byte in [31:24]
        int          stall;      // extra empty clocks before the second byte
        bit          mid_send;
        int          exp_cycles; // send edge to done pulse
    } vec_t;

    vec_t vecs[5];
    logic [1:0] trace[20];

    int n_checks = 0;
    int n_fail   = 0;

    int cyc, n_consume, n_done, done_at;
    bit stall_pend;
    int stall_len, stall_left, stall_edges, stall_bad;
    logic stall_b0;
    logic [7:0] fq[$];

    // receiver model state
    int dstate, st_cnt, bitcnt;
    logic expect1;
    logic [7:0] dsh;
    logic [7:0] rx[$];
    bit start_seen, end_seen;
    logic p1q, p5q;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic arm_decoder();
        dstate = 0; st_cnt = 0; bitcnt = 0; expect1 = 1'b1; dsh = 8'h00;
        rx.delete(); start_seen = 1'b0; end_seen = 1'b0;
        p1q = pin1; p5q = pin5;
    endtask

    task automatic shift_bit(input logic b);
        dsh = {dsh[6:0], b};
        bitcnt++;
        if (bitcnt == 8) begin
            rx.push_back(dsh);
            bitcnt = 0;
        end
    endtask

    // pin1 fall samples pin5, pin5 fall samples pin1; a pin5 fall where a
    // pin1 fall is due marks the end pattern
    task automatic decode();
        logic f1, f5;
        f1 = p1q & ~pin1;
        f5 = p5q & ~pin5;
        case (dstate)
            0: if (f5 && !pin1) begin st_cnt = 1; dstate = 1; end
            1: if (f5) begin
                   st_cnt++;
                   if (st_cnt == 4) begin start_seen = 1'b1; dstate = 2; end
               end
            2: if (f5) begin dstate = 3; expect1 = 1'b1; bitcnt = 0; end
            3: begin
                   if (f1 && expect1) begin shift_bit(pin5); expect1 = 1'b0; end
                   if (f5) begin
                       if (expect1) begin end_seen = 1'b1; dstate = 4; end
                       else begin shift_bit(pin1); expect1 = 1'b1; end
                   end
               end
            default: ;
        endcase
        p1q = pin1;
        p5q = pin5;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (stall_left >= 2 && stall_left <= 41) begin
            if (pin1 !== p1q || pin5 !== p5q) stall_edges++;
            if (pin1 !== stall_b0 || pin5 !== 1'b0) stall_bad++;
        end
        decode();
        if (fifo_consume === 1'b1) begin
            n_consume++;
            if (fq.size() > 0) void'(fq.pop_front());
            if (stall_pend) begin
                stall_pend = 1'b0;
                stall_left = 16 * SLOT + stall_len;
            end
        end else if (stall_left > 0) begin
            stall_left--;
        end
        if (done === 1'b1) begin
            n_done++;
            if (done_at < 0) done_at = cyc - 1;
        end
        fifo_empty = (stall_left != 0) || (fq.size() == 0);
        fifo_data  = (fq.size() > 0) ? fq[0] : 8'h00;
    endtask

    task automatic start_frame(input int len);
        arm_decoder();
        n_consume = 0; n_done = 0; done_at = -1; cyc = 0;
        frame_len = LEN_W'(len);
        send = 1'b1;
        step();
        send = 1'b0;
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        fq.delete();
        for (int i = 0; i < v.len; i++) fq.push_back(v.bytes[31 - 8 * i -: 8]);
        stall_pend = (v.stall > 0); stall_len = v.stall; stall_left = 0;
        stall_edges = 0; stall_bad = 0; stall_b0 = v.bytes[24];
        fifo_empty = (fq.size() == 0);
        fifo_data  = (fq.size() > 0) ? fq[0] : 8'h00;
        start_frame(v.len);
        while (done_at < 0 && cyc < 3000) begin
            send = (v.mid_send && (cyc == 40 || cyc == 150)) ? 1'b1 : 1'b0;
            step();
        end
        send = 1'b0;
        check({tag, " done_seen"}, longint'(done_at >= 0), 1);
        check({tag, " cycles"}, done_at, v.exp_cycles);
        check({tag, " consumes"}, n_consume, v.len);
        check({tag, " oe_busy_at_done"}, {oe, busy}, 0);
        check({tag, " pins_at_done"}, {pin1, pin5}, 3);
        check({tag, " start_detected"}, start_seen, 1);
        check({tag, " end_detected"}, end_seen, 1);
        check({tag, " rx_count"}, rx.size(), v.len);
        for (int i = 0; i < v.len && i < rx.size(); i++)
            check({tag, " rx_byte"}, rx[i], v.bytes[31 - 8 * i -: 8]);
        for (int i = 0; i < 3; i++) step();
        check({tag, " done_pulses"}, n_done, 1);
        if (v.stall > 0) begin
            check({tag, " stall_edges"}, stall_edges, 0);
            check({tag, " stall_hold"}, stall_bad, 0);
        end
    endtask

    initial begin
        vecs[0] = '{len: 0, bytes: 32'h0000_0000, stall: 0,  mid_send: 1'b0, exp_cycles: 81};
        vecs[1] = '{len: 1, bytes: 32'hA500_0000, stall: 0,  mid_send: 1'b0, exp_cycles: 146};
        vecs[2] = '{len: 4, bytes: 32'h00FF_3C81, stall: 0,  mid_send: 1'b0, exp_cycles: 341};
        vecs[3] = '{len: 2, bytes: 32'h5BC3_0000, stall: 37, mid_send: 1'b0, exp_cycles: 248};
        vecs[4] = '{len: 2, bytes: 32'h6E19_0000, stall: 0,  mid_send: 1'b1, exp_cycles: 211};
        trace = '{2'b11, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01,
                  2'b11, 2'b10, 2'b11, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b11, 2'b11};

        rst = 1'b1; send = 1'b0; frame_len = '0; fifo_data = 8'h00; fifo_empty = 1'b1;
        stall_left = 0; stall_pend = 1'b0; stall_len = 0; stall_b0 = 1'b0;
        arm_decoder();
        for (int i = 0; i < 3; i++) step();
        check("reset_pins", {pin1, pin5}, 3);
        check("reset_ctrl", {oe, busy, done, fifo_consume}, 0);
        rst = 1'b0;
        step();

        // exact 20-slot start+end trace for an empty frame
        fq.delete();
        start_frame(0);
        check("launch_oe", oe, 0);
        check("launch_pins", {pin1, pin5}, 3);
        for (int k = 1; k <= 20 * SLOT; k++) begin
            step();
            check("trace", {done, oe, busy, pin1, pin5}, {3'b011, trace[(k - 1) / SLOT]});
        end
        step();
        check("trace_done", {done, oe, busy, pin1, pin5}, 5'b10011);
        check("trace_consumes", n_consume, 0);
        send = 1'b1;
        step();
        send = 1'b0;
        step();
        check("send_at_done_ignored", {oe, busy, done}, 0);
        for (int i = 0; i < 4; i++) step();

        for (int i = 0; i < 5; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

        // reset during data slot 7 of the first byte
        fq.delete();
        fq.push_back(8'h5B);
        fifo_empty = 1'b0; fifo_data = 8'h5B;
        start_frame(1);
        while (cyc < 80) step();
        check("pre_reset_busy", {oe, busy}, 3);
        check("pre_reset_consumed", n_consume, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midreset_pins", {pin1, pin5}, 3);
        check("midreset_ctrl", {oe, busy, done}, 0);
        for (int i = 0; i < 200; i++) step();
        check("midreset_no_done", n_done, 0);
        check("midreset_idle", {oe, busy}, 0);
        run_frame(vecs[2], "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
